// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for alu_exec_unit: opcodes, funct7 constants, ALU ops and FSM states.
// Decode helpers are reused by the top level and the M-extension datapath.
package alu_exec_unit_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [6:0] FNC7_0      = 7'b0000000;
  localparam logic [6:0] FNC7_1      = 7'b0100000;
  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_COPY_B,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  function automatic alu_op_e decode_arith(input logic [2:0] f3, input logic alt,
                                           input logic rtype);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = (rtype && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_e decode_muldiv(input logic [2:0] f3);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative XLEN-step magnitude multiplier (shift-add) / restoring divider.
// done_o is high in the final step; result_o already includes that step and the sign fix-up.
module alu_muldiv_iter
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic            run_q, neg_q, is_div_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  alu_op_e         op_q;

  logic            a_neg, b_neg;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [2*XLEN-1:0] prod_fix;

  assign a_neg = (op_i inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a_i[XLEN-1];
  assign b_neg = (op_i inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM}) && b_i[XLEN-1];

  // hi holds product-high / partial remainder, lo holds multiplier / quotient.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!rem_diff[XLEN]) begin
        hi_d = rem_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    unique case (op_q)
      ALU_MUL:                        result_o = prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              result_o = neg_q ? -lo_d : lo_d;
      default:                        result_o = neg_q ? -hi_d : hi_d;
    endcase
  end

  assign done_o = run_q && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_q     <= ALU_MUL;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      op_q     <= op_i;
      is_div_q <= op_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      neg_q    <= (op_i == ALU_REM) ? a_neg : (a_neg ^ b_neg);
      hi_q     <= '0;
      lo_q     <= a_neg ? -a_i : a_i;
      opnd_q   <= b_neg ? -b_i : b_i;
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Decoding ALU execute unit with valid/ready handshake and registered result/illegal flag.
// Define ALU_M_EXT_EN to add RV32M ops on the iterative alu_muldiv_iter datapath.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res;
  logic            illegal_q, illegal_d;
  alu_op_e         dec_op;
  logic            dec_ill, accept, go_iter;
  logic [SHW-1:0]  shamt;
  logic            unused_funct7;

  // Only bits 0 and 5 steer decode outside the full M-op match.
  assign unused_funct7 = ^{funct7[6], funct7[4:1]};

  always_comb begin
    dec_op  = ALU_ADD;
    dec_ill = 1'b0;
    unique case (opcode)
      OPC_ARI_RTYPE: begin
        if (!funct7[0]) dec_op = decode_arith(funct3, funct7[5], 1'b1);
`ifdef ALU_M_EXT_EN
        else if (funct7 == FNC7_MULDIV) dec_op = decode_muldiv(funct3);
`endif
        else dec_ill = 1'b1;
      end
      OPC_ARI_ITYPE: dec_op = decode_arith(funct3, funct7[5], 1'b0);
      OPC_BRANCH:    dec_ill = funct3 inside {3'b010, 3'b011};
      OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: dec_op = ALU_ADD;
      OPC_LUI:       dec_op = ALU_COPY_B;
      default:       dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_M_EXT_EN
  logic            div_zero, div_ovf, md_start, md_done;
  logic [XLEN-1:0] md_result;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Divide-by-zero and signed overflow resolve in the ALU path and never start the iterator.
  always_comb begin
    go_iter = 1'b0;
    unique case (dec_op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: go_iter = 1'b1;
      ALU_DIV, ALU_REM:                         go_iter = !div_zero && !div_ovf;
      ALU_DIVU, ALU_REMU:                       go_iter = !div_zero;
      default:                                  go_iter = 1'b0;
    endcase
  end

  assign md_start = accept && go_iter;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (md_start),
    .op_i     (dec_op),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  assign go_iter = 1'b0;
`endif

  always_comb begin
    shamt   = b[SHW-1:0];
    alu_res = '0;
    unique case (dec_op)
      ALU_ADD:    alu_res = a + b;
      ALU_SUB:    alu_res = a - b;
      ALU_SLL:    alu_res = a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    alu_res = a ^ b;
      ALU_SRL:    alu_res = a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(a) >>> shamt);
      ALU_OR:     alu_res = a | b;
      ALU_AND:    alu_res = a & b;
      ALU_COPY_B: alu_res = b;
`ifdef ALU_M_EXT_EN
      ALU_DIV, ALU_DIVU: alu_res = div_zero ? '1 : a;
      ALU_REM, ALU_REMU: alu_res = div_zero ? a : '0;
`endif
      default:    alu_res = '0;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_BUSY: begin
`ifdef ALU_M_EXT_EN
        if (md_done) begin
          state_d   = ST_DONE;
          result_d  = md_result;
          illegal_d = 1'b0;
        end
`endif
      end
      default: begin
        if (accept) begin
          if (go_iter) begin
            state_d = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            result_d  = dec_ill ? '0 : alu_res;
            illegal_d = dec_ill;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
